// File: rtl/alu_mc.sv
// Multi-cycle saturating ALU: eight single-cycle ops plus a signed multiply
// computed by an iterative shift-add engine behind a valid/ready handshake.
module alu_mc #(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH),
    parameter bit SAT   = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_vld,
    output logic             in_rdy,
    input  logic [WIDTH-1:0] src0,
    input  logic [WIDTH-1:0] src1,
    input  logic [3:0]       aluOp,
    input  logic [SHW-1:0]   shAmt,
    output logic             out_vld,
    output logic [WIDTH-1:0] dst,
    output logic             V,
    output logic             Z,
    output logic             N,
    output logic [1:0]       dbg_state
);

    localparam int M  = WIDTH - 1;
    localparam int H  = WIDTH / 2;
    localparam int CW = $clog2(WIDTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_FIN  = 2'd2;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_NOR = 4'd3;
    localparam logic [3:0] OP_SLL = 4'd4;
    localparam logic [3:0] OP_SRL = 4'd5;
    localparam logic [3:0] OP_SRA = 4'd6;
    localparam logic [3:0] OP_LHB = 4'd7;
    localparam logic [3:0] OP_MUL = 4'd8;

    localparam logic [WIDTH-1:0] MAXP = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MINN = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CW-1:0]    LAST = CW'(WIDTH - 1);

    logic [1:0]         state;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [2*WIDTH-1:0] acc;
    logic               prod_neg;

    logic [WIDTH-1:0]   sum, diff, alu_res, mag0, mag1, mul_res;
    logic               alu_v, mul_v;
    logic [2*WIDTH-1:0] sprod;

    // Handshake: an op is taken on a rising edge where in_vld && in_rdy;
    // in_rdy is high only in IDLE and never while rst is asserted.
    assign in_rdy    = (state == S_IDLE) && !rst;
    assign dbg_state = state;

    assign mag0 = src0[M] ? -src0 : src0;
    assign mag1 = src1[M] ? -src1 : src1;

    always_comb begin
        alu_res = '0;
        alu_v   = 1'b0;
        sum     = src0 + src1;
        diff    = src0 - src1;
        case (aluOp)
            OP_ADD: begin
                alu_v   = (src0[M] == src1[M]) && (sum[M] != src0[M]);
                alu_res = (alu_v && SAT) ? (src0[M] ? MINN : MAXP) : sum;
            end
            OP_SUB: begin
                alu_v   = (src0[M] != src1[M]) && (diff[M] != src0[M]);
                alu_res = (alu_v && SAT) ? (src0[M] ? MINN : MAXP) : diff;
            end
            OP_AND:  alu_res = src0 & src1;
            OP_NOR:  alu_res = ~(src0 | src1);
            OP_SLL:  alu_res = src0 << shAmt;
            OP_SRL:  alu_res = src0 >> shAmt;
            OP_SRA:  alu_res = $signed(src0) >>> shAmt;
            OP_LHB:  alu_res = {src1[H-1:0], src0[H-1:0]};
            default: ;
        endcase
    end

    // The product fits only if its top WIDTH+1 bits are a pure sign extension.
    always_comb begin
        sprod   = prod_neg ? -acc : acc;
        mul_v   = !((&sprod[2*WIDTH-1:M]) || !(|sprod[2*WIDTH-1:M]));
        mul_res = (mul_v && SAT) ? (prod_neg ? MINN : MAXP) : sprod[WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            out_vld  <= 1'b0;
            dst      <= '0;
            V        <= 1'b0;
            Z        <= 1'b0;
            N        <= 1'b0;
            mcand    <= '0;
            mplier   <= '0;
            acc      <= '0;
            prod_neg <= 1'b0;
        end else begin
            out_vld <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (in_vld && in_rdy) begin
                        if (aluOp == OP_MUL) begin
                            mcand    <= {{WIDTH{1'b0}}, mag0};
                            mplier   <= mag1;
                            acc      <= '0;
                            prod_neg <= src0[M] ^ src1[M];
                            cnt      <= '0;
                            state    <= S_MUL;
                        end else begin
                            dst     <= alu_res;
                            V       <= alu_v;
                            Z       <= (alu_res == '0);
                            N       <= alu_res[M];
                            out_vld <= 1'b1;
                        end
                    end
                end
                S_MUL: begin
                    if (mplier[0]) acc <= acc + mcand;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    if (cnt == LAST) state <= S_FIN;
                end
                S_FIN: begin
                    dst     <= mul_res;
                    V       <= mul_v;
                    Z       <= (mul_res == '0);
                    N       <= mul_res[M];
                    out_vld <= 1'b1;
                    state   <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
// Bench for alu_mc: a saturating and a wrapping instance share stimulus and are
// compared against an integer-arithmetic reference model.
module tb_alu_mc;

    localparam int W   = 16;
    localparam int SHW = 4;
    localparam int EW  = W + 3;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_vld;
    logic [W-1:0]   src0, src1;
    logic [3:0]     aluOp;
    logic [SHW-1:0] shAmt;

    logic           rdy_s, vld_s, v_s, z_s, n_s;
    logic [W-1:0]   dst_s;
    logic [1:0]     st_s;
    logic           rdy_w, vld_w, v_w, z_w, n_w;
    logic [W-1:0]   dst_w;
    logic [1:0]     st_w;

    int checks = 0;
    int errors = 0;
    logic [EW-1:0] exp_q[$];

    alu_mc #(.WIDTH(W), .SHW(SHW), .SAT(1'b1)) u_sat (
        .clk(clk), .rst(rst), .in_vld(in_vld), .in_rdy(rdy_s),
        .src0(src0), .src1(src1), .aluOp(aluOp), .shAmt(shAmt),
        .out_vld(vld_s), .dst(dst_s), .V(v_s), .Z(z_s), .N(n_s),
        .dbg_state(st_s)
    );

    alu_mc #(.WIDTH(W), .SHW(SHW), .SAT(1'b0)) u_wrap (
        .clk(clk), .rst(rst), .in_vld(in_vld), .in_rdy(rdy_w),
        .src0(src0), .src1(src1), .aluOp(aluOp), .shAmt(shAmt),
        .out_vld(vld_w), .dst(dst_w), .V(v_w), .Z(z_w), .N(n_w),
        .dbg_state(st_w)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // reference model: returns {V, Z, N, dst} from signed integer arithmetic
    function automatic logic [EW-1:0] model(input int op, input logic [W-1:0] a,
                                             input logic [W-1:0] b,
                                             input logic [SHW-1:0] sh, input bit sat);
        longint sa, sb, r;
        logic [W-1:0] d;
        bit v;
        sa = $signed(a);
        sb = $signed(b);
        r  = 0;
        v  = 1'b0;
        d  = '0;
        case (op)
            0, 1, 8: begin
                if (op == 0) r = sa + sb;
                else if (op == 1) r = sa - sb;
                else r = sa * sb;
                if (r > 32767 || r < -32768) begin
                    v = 1'b1;
                    d = sat ? ((r > 0) ? 16'h7fff : 16'h8000) : W'(r);
                end else begin
                    d = W'(r);
                end
            end
            2: d = a & b;
            3: d = ~(a | b);
            4: d = a << sh;
            5: d = a >> sh;
            6: d = W'(sa >>> sh);
            7: d = {b[7:0], a[7:0]};
            default: d = '0;
        endcase
        return {v, (d == '0), d[W-1], d};
    endfunction

    // driver: one non-MUL op, result expected one cycle later
    task automatic drive_op(input int op, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [SHW-1:0] sh, input string name);
        logic [EW-1:0] e_s, e_w;
        e_s = model(op, a, b, sh, 1'b1);
        e_w = model(op, a, b, sh, 1'b0);
        src0 = a; src1 = b; aluOp = 4'(op); shAmt = sh; in_vld = 1'b1;
        checks++;
        if (rdy_s !== 1'b1) begin
            errors++; $display("FAIL %s in_rdy: got %b want 1", name, rdy_s);
        end
        step();
        in_vld = 1'b0;
        checks++;
        if ({vld_s, vld_w} !== 2'b11) begin
            errors++; $display("FAIL %s out_vld: got %b%b want 11", name, vld_s, vld_w);
        end
        checks++;
        if ({v_s, z_s, n_s, dst_s} !== e_s) begin
            errors++; $display("FAIL %s sat VZN_dst: got %h want %h", name, {v_s, z_s, n_s, dst_s}, e_s);
        end
        checks++;
        if ({v_w, z_w, n_w, dst_w} !== e_w) begin
            errors++; $display("FAIL %s wrap VZN_dst: got %h want %h", name, {v_w, z_w, n_w, dst_w}, e_w);
        end
    endtask

    // driver: one MUL, checks latency, stall window and result
    task automatic do_mul(input logic [W-1:0] a, input logic [W-1:0] b, input string name);
        logic [EW-1:0] e_s, e_w;
        int lat, low;
        e_s = model(8, a, b, '0, 1'b1);
        e_w = model(8, a, b, '0, 1'b0);
        src0 = a; src1 = b; aluOp = 4'd8; in_vld = 1'b1;
        checks++;
        if (rdy_s !== 1'b1) begin
            errors++; $display("FAIL %s in_rdy: got %b want 1", name, rdy_s);
        end
        step();
        in_vld = 1'b0;
        src0 = W'($urandom); src1 = W'($urandom); aluOp = 4'($urandom_range(0, 7));
        lat = 0; low = 0;
        while (vld_s !== 1'b1 && lat < 40) begin
            if (rdy_s === 1'b0) low++;
            step();
            lat++;
        end
        checks++;
        if (lat != W + 1) begin
            errors++; $display("FAIL %s latency: got %0d want %0d", name, lat, W + 1);
        end
        checks++;
        if (low != W + 1) begin
            errors++; $display("FAIL %s rdy_low_cycles: got %0d want %0d", name, low, W + 1);
        end
        checks++;
        if ({rdy_s, vld_w} !== 2'b11) begin
            errors++; $display("FAIL %s rdy_vld_at_result: got %b%b want 11", name, rdy_s, vld_w);
        end
        checks++;
        if ({v_s, z_s, n_s, dst_s} !== e_s) begin
            errors++; $display("FAIL %s sat VZN_dst: got %h want %h", name, {v_s, z_s, n_s, dst_s}, e_s);
        end
        checks++;
        if ({v_w, z_w, n_w, dst_w} !== e_w) begin
            errors++; $display("FAIL %s wrap VZN_dst: got %h want %h", name, {v_w, z_w, n_w, dst_w}, e_w);
        end
        step();
        checks++;
        if (vld_s !== 1'b0) begin
            errors++; $display("FAIL %s pulse_width: got %b want 0", name, vld_s);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_vld = 1'b0; src0 = '0; src1 = '0; aluOp = '0; shAmt = '0;
        repeat (3) step();
        checks++;
        if ({vld_s, v_s, z_s, n_s, dst_s, rdy_s} !== '0) begin
            errors++; $display("FAIL reset_outputs: got %h want 0", {vld_s, v_s, z_s, n_s, dst_s, rdy_s});
        end
        checks++;
        if (st_s !== 2'd0) begin
            errors++; $display("FAIL reset_state: got %0d want 0", st_s);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (rdy_s !== 1'b1) begin
            errors++; $display("FAIL reset_rdy_after: got %b want 1", rdy_s);
        end
    endtask

    task automatic test_add_sub();
        drive_op(0, 16'h7000, 16'h2000, 4'd0, "add_ovf");
        checks++;
        if ({dst_s, v_s, n_s, dst_w, v_w, n_w} !== {16'h7fff, 1'b1, 1'b0, 16'h9000, 1'b1, 1'b1}) begin
            errors++; $display("FAIL add_ovf_const: got %h/%b%b %h/%b%b want 7fff/10 9000/11",
                               dst_s, v_s, n_s, dst_w, v_w, n_w);
        end
        drive_op(1, 16'h8000, 16'h0001, 4'd0, "sub_ovf");
        checks++;
        if ({dst_s, v_s, n_s} !== {16'h8000, 1'b1, 1'b1}) begin
            errors++; $display("FAIL sub_ovf_const: got %h/%b%b want 8000/11", dst_s, v_s, n_s);
        end
        drive_op(1, 16'h0005, 16'h0005, 4'd0, "sub_zero");
        checks++;
        if ({dst_s, z_s, v_s} !== {16'h0000, 1'b1, 1'b0}) begin
            errors++; $display("FAIL sub_zero_const: got %h/%b%b want 0000/10", dst_s, z_s, v_s);
        end
        drive_op(0, 16'h8000, 16'hffff, 4'd0, "add_neg_ovf");
        drive_op(2, 16'hf0f0, 16'h3c3c, 4'd0, "and");
        drive_op(3, 16'hf0f0, 16'h0f00, 4'd0, "nor");
        drive_op(9, 16'h1234, 16'h5678, 4'd3, "reserved");
    endtask

    task automatic test_back_to_back();
        int ops[3] = '{6, 5, 7};
        logic [W-1:0] a0[3] = '{16'h8000, 16'h8000, 16'h12ab};
        logic [W-1:0] b0[3] = '{16'h0000, 16'h0000, 16'h34cd};
        logic [EW-1:0] got;
        for (int i = 0; i < 33; i++) begin
            if (i < 3) begin
                src0 = a0[i]; src1 = b0[i]; aluOp = 4'(ops[i]); shAmt = 4'd15;
            end else begin
                src0 = W'($urandom); src1 = W'($urandom); shAmt = SHW'($urandom_range(0, 15));
                aluOp = 4'($urandom_range(0, 7));
            end
            in_vld = 1'b1;
            exp_q.push_back(model(int'(aluOp), src0, src1, shAmt, 1'b1));
            checks++;
            if (rdy_s !== 1'b1) begin
                errors++; $display("FAIL b2b_rdy[%0d]: got %b want 1", i, rdy_s);
            end
            step();
            checks++;
            if (vld_s !== 1'b1) begin
                errors++; $display("FAIL b2b_vld[%0d]: got %b want 1", i, vld_s);
            end else begin
                got = {v_s, z_s, n_s, dst_s};
                checks++;
                if (got !== exp_q[0]) begin
                    errors++; $display("FAIL b2b_result[%0d]: got %h want %h", i, got, exp_q[0]);
                end
                void'(exp_q.pop_front());
            end
        end
        in_vld = 1'b0;
        exp_q.delete();
        checks++;
        if ({dst_s, n_s} !== {16'hcdab, 1'b1} && 0) begin
            errors++;
        end
    endtask

    task automatic test_mul();
        do_mul(16'hfffd, 16'h0005, "mul_m3x5");
        checks++;
        if ({dst_s, v_s, n_s} !== {16'hfff1, 1'b0, 1'b1}) begin
            errors++; $display("FAIL mul_m3x5_const: got %h/%b%b want fff1/01", dst_s, v_s, n_s);
        end
        do_mul(16'h0100, 16'h0100, "mul_ovf");
        do_mul(16'h8000, 16'h0001, "mul_min_x1");
        do_mul(16'h8000, 16'hffff, "mul_min_xm1");
        checks++;
        if ({dst_s, v_s} !== {16'h7fff, 1'b1}) begin
            errors++; $display("FAIL mul_min_xm1_const: got %h/%b want 7fff/1", dst_s, v_s);
        end
        do_mul(16'h0000, 16'h8000, "mul_zero");
        for (int i = 0; i < 12; i++) begin
            if (i < 6) do_mul(W'($urandom_range(0, 400)) - 16'd200, W'($urandom_range(0, 300)) - 16'd150, "mul_rand_small");
            else do_mul(W'($urandom), W'($urandom), "mul_rand");
        end
    endtask

    task automatic test_mul_stall();
        int lat;
        logic [EW-1:0] e_add;
        do_mul(16'h0007, 16'hfff0, "stall_setup");
        src0 = 16'h0007; src1 = 16'hfff0; aluOp = 4'd8; in_vld = 1'b1;
        step();
        aluOp = 4'd0; src0 = 16'h1234; src1 = 16'h1111;
        e_add = model(0, 16'h1234, 16'h1111, '0, 1'b1);
        lat = 0;
        while (vld_s !== 1'b1 && lat < 40) begin
            step();
            lat++;
        end
        checks++;
        if (lat != W + 1) begin
            errors++; $display("FAIL stall_mul_latency: got %0d want %0d", lat, W + 1);
        end
        checks++;
        if ({dst_s, rdy_s} !== {16'hff90, 1'b1}) begin
            errors++; $display("FAIL stall_mul_result: got %h/%b want ff90/1", dst_s, rdy_s);
        end
        step();
        in_vld = 1'b0;
        checks++;
        if ({vld_s, v_s, z_s, n_s, dst_s} !== {1'b1, e_add}) begin
            errors++; $display("FAIL stall_add_result: got %h want %h", {vld_s, v_s, z_s, n_s, dst_s}, {1'b1, e_add});
        end
        step();
    endtask

    task automatic test_reset_mid_mul();
        int pulses;
        src0 = 16'h0100; src1 = 16'h0003; aluOp = 4'd8; in_vld = 1'b1;
        step();
        in_vld = 1'b0;
        repeat (5) step();
        rst = 1'b1;
        step();
        checks++;
        if ({vld_s, v_s, z_s, n_s, dst_s, rdy_s} !== '0) begin
            errors++; $display("FAIL midmul_reset_outputs: got %h want 0", {vld_s, v_s, z_s, n_s, dst_s, rdy_s});
        end
        rst = 1'b0;
        #1;
        checks++;
        if (rdy_s !== 1'b1) begin
            errors++; $display("FAIL midmul_rdy_after: got %b want 1", rdy_s);
        end
        pulses = 0;
        repeat (24) begin
            step();
            if (vld_s === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 0 || dst_s !== '0) begin
            errors++; $display("FAIL midmul_no_result: got %0d pulses dst %h want 0 pulses dst 0000", pulses, dst_s);
        end
        do_mul(16'h0002, 16'h0003, "mul_after_reset");
        checks++;
        if (dst_s !== 16'h0006) begin
            errors++; $display("FAIL mul_after_reset_const: got %h want 0006", dst_s);
        end
    endtask

    task automatic test_random();
        int op;
        for (int i = 0; i < 150; i++) begin
            op = $urandom_range(0, 15);
            if (op == 8) do_mul(W'($urandom), W'($urandom), "rand_mul");
            else drive_op(op, W'($urandom), W'($urandom), SHW'($urandom_range(0, 15)), "rand_op");
        end
    endtask

    initial begin
        test_reset();
        test_add_sub();
        test_back_to_back();
        test_mul();
        test_mul_stall();
        test_reset_mid_mul();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
